// File: rtl/fft_arith_pkg.sv
// Shared arithmetic constants and types for the radix-16 FFT butterfly datapath.
package fft_arith_pkg;

    localparam int unsigned WIDTH      = 24;
    localparam int unsigned CLA_GROUPS = 6;
    localparam int unsigned GROUP_W    = 4;

    typedef logic [23:0] word_t;

    localparam word_t MODULUS = 24'd16760833;

endpackage

// File: rtl/cla24_adder.sv
// 24-bit carry-lookahead adder: six 4-bit group generators plus a second-level
// lookahead that forms every group carry-in directly from cin and the group terms.

// One 4-bit lookahead group: local sum plus group generate/propagate.
module cla4_group (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       gg,
    output logic       gp
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    // Bit-level generate/propagate, in-group carries and group terms.
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        sum  = p ^ c;
        gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        gp   = &p;
    end
endmodule

module cla24_adder
    import fft_arith_pkg::*;
(
    input  logic [23:0] a,
    input  logic [23:0] b,
    input  logic        cin,
    output logic [23:0] sum,
    output logic        cout
);
    logic [CLA_GROUPS-1:0] grp_g;
    logic [CLA_GROUPS-1:0] grp_p;
    logic [CLA_GROUPS:0]   grp_c;

    for (genvar gi = 0; gi < CLA_GROUPS; gi++) begin : g_grp
        cla4_group u_grp (
            .a   (a[gi*GROUP_W +: GROUP_W]),
            .b   (b[gi*GROUP_W +: GROUP_W]),
            .cin (grp_c[gi]),
            .sum (sum[gi*GROUP_W +: GROUP_W]),
            .gg  (grp_g[gi]),
            .gp  (grp_p[gi])
        );
    end

    // Second-level lookahead: each group carry is a flat sum of products, no ripple.
    always_comb begin
        logic acc;
        logic prod;
        acc      = 1'b0;
        prod     = 1'b0;
        grp_c    = '0;
        grp_c[0] = cin;
        for (int unsigned i = 1; i <= CLA_GROUPS; i++) begin
            acc  = 1'b0;
            for (int unsigned j = 0; j < i; j++) begin
                prod = grp_g[j];
                for (int unsigned k = j + 1; k < i; k++) begin
                    prod = prod & grp_p[k];
                end
                acc = acc | prod;
            end
            prod = cin;
            for (int unsigned k = 0; k < i; k++) begin
                prod = prod & grp_p[k];
            end
            grp_c[i] = acc | prod;
        end
    end

    assign cout = grp_c[CLA_GROUPS];
endmodule

// File: rtl/cla24_modadd_pipe.sv
// Two-stage modular add/subtract: stage 1 forms the raw CLA sum/difference and
// the reduction flag, stage 2 applies a single +/- MODULUS correction.
module cla24_modadd_pipe #(
    parameter int unsigned        WIDTH   = 24,
    parameter logic [WIDTH-1:0]   MODULUS = 24'd16760833
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sub,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    import fft_arith_pkg::*;

    logic  s1_valid;
    word_t s1_r;
    logic  s1_f;
    logic  s1_sub;
    logic  s2_valid;

    logic  s2_adv;
    word_t s1_sum;
    logic  s1_cout;
    logic  s1_f_next;
    word_t corr_b;
    logic  corr_cin;
    word_t corr_sum;
    logic  corr_cout;

    // Subtraction is a + ~b + 1 through the same adder.
    cla24_adder u_s1_add (
        .a    (in_a),
        .b    (in_sub ? ~in_b : in_b),
        .cin  (in_sub),
        .sum  (s1_sum),
        .cout (s1_cout)
    );

    // Correction adder: r - M as r + ~M + 1, r + M directly, or r + 0.
    cla24_adder u_s2_corr (
        .a    (s1_r),
        .b    (corr_b),
        .cin  (corr_cin),
        .sum  (corr_sum),
        .cout (corr_cout)
    );

    // Handshake and flag/correction-operand selection.
    always_comb begin
        s2_adv    = !s2_valid || out_ready;
        in_ready  = !s1_valid || s2_adv;
        s1_f_next = in_sub ? !s1_cout : (s1_cout || (s1_sum >= MODULUS));
        corr_b    = '0;
        corr_cin  = 1'b0;
        if (s1_f) begin
            corr_b   = s1_sub ? MODULUS : ~MODULUS;
            corr_cin = !s1_sub;
        end
    end

    // Pipeline registers; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_r     <= '0;
            s1_f     <= 1'b0;
            s1_sub   <= 1'b0;
            s2_valid <= 1'b0;
            out_data <= '0;
        end else begin
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= corr_sum;
                end
            end
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_r   <= s1_sum;
                    s1_f   <= s1_f_next;
                    s1_sub <= in_sub;
                end
            end
        end
    end

    assign out_valid = s2_valid;

    logic unused_cout;
    assign unused_cout = corr_cout;
endmodule

// File: tb/tb_cla24_modadd_pipe.sv
// Scoreboard bench for cla24_modadd_pipe.
module tb_cla24_modadd_pipe;
    localparam logic [23:0] M = 24'd16760833;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sub;
    logic [23:0] in_a;
    logic [23:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned n_out = 0;
    logic [23:0] sb_q[$];
    logic        prev_hold = 1'b0;
    logic [23:0] prev_data = '0;

    cla24_modadd_pipe #(.WIDTH(24), .MODULUS(M)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sub    (in_sub),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] model(input logic sub, input logic [23:0] a, input logic [23:0] b);
        logic [24:0] s;
        logic [23:0] r;
        if (!sub) begin
            s = {1'b0, a} + {1'b0, b};
            r = s[23:0];
            if (s[24] || (r >= M)) return r - M;
            return r;
        end
        r = a - b;
        if (a < b) return r + M;
        return r;
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic drive_op(input logic sub, input logic [23:0] a, input logic [23:0] b);
        int unsigned n = 0;
        in_valid = 1'b1;
        in_sub   = sub;
        in_a     = a;
        in_b     = b;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
        else sb_q.push_back(model(sub, a, b));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Output monitor: in-order scoreboard and hold-stability while stalled.
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_data", {8'd0, out_data}, {8'd0, prev_data});
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (sb_q.size() == 0) check("unexpected_out", {8'd0, out_data}, 32'hFFFF_FFFF);
                else check("result", {8'd0, out_data}, {8'd0, sb_q.pop_front()});
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
        end
    end

    task automatic drain();
        int unsigned n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("drain", sb_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned base;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sub    = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {8'd0, out_data}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Directed latency check: 5 + 7.
        drive_op(1'b0, 24'd5, 24'd7);
        @(negedge clk);
        check("lat_c1_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("lat_c2_valid", {31'd0, out_valid}, 32'd1);
        check("lat_c2_data", {8'd0, out_data}, 32'd12);
        @(negedge clk);
        check("lat_c3_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Boundary values.
        drive_op(1'b0, 24'd16760832, 24'd1);
        drive_op(1'b0, 24'd16760832, 24'd16760832);
        drive_op(1'b1, 24'd3, 24'd5);
        drive_op(1'b1, 24'd0, 24'd0);
        drive_op(1'b1, 24'd9, 24'd4);
        drive_op(1'b0, 24'h7FFFFF, 24'h000001);
        drive_op(1'b0, 24'hFFFFFF, 24'hFFFFFF);
        drive_op(1'b1, 24'h000000, 24'hFFFFFF);
        drive_op(1'b0, 24'hFFF000, 24'h000FFF);
        drain();
        check("known_add_carry", {8'd0, model(1'b0, 24'd16760832, 24'd16760832)}, 32'd16760831);

        // Mixed stream with a 3-cycle stall in the middle.
        base = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    drive_op(i[0], 24'($urandom_range(0, 32'(M) - 1)), 24'($urandom_range(0, 32'(M) - 1)));
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                @(negedge clk);
                check("stall_in_ready", {31'd0, in_ready}, 32'd0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("stream_count", n_out - base, 32'd8);

        // Reset with both stages full and the output stalled.
        out_ready = 1'b0;
        drive_op(1'b0, 24'd100, 24'd200);
        drive_op(1'b1, 24'd50, 24'd60);
        @(negedge clk);
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        check("full_out_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
        out_ready = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_out_data", {8'd0, out_data}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        drive_op(1'b1, 24'd9, 24'd4);
        @(negedge clk);
        check("post_rst_c1_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("post_rst_c2_valid", {31'd0, out_valid}, 32'd1);
        check("post_rst_c2_data", {8'd0, out_data}, 32'd5);
        @(posedge clk);
        #1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1);
    end
endmodule
